// File: rtl/tick_rr_scheduler_pkg.sv
// Shared types, defaults and the round-robin pick function for the tick scheduler.
package tick_sched_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 16;

  // Widest requester vector rr_pick can search.
  localparam int MAX_N  = 16;
  localparam int IDX_W  = $clog2(MAX_N);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Returns the first requester at or after ptr, wrapping modulo n.
  // Only bits [n-1:0] of req are looked at; ptr must be below n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input int               ptr,
                                       input int               n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!r.valid && req[j[IDX_W-1:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_rr_scheduler_if.sv
// Control, request and grant signals between the scheduler and its host.
interface tick_rr_scheduler_if #(
  parameter int N     = tick_sched_pkg::DEFAULT_N,
  parameter int WIDTH = tick_sched_pkg::DEFAULT_WIDTH
);

  logic                 enable;
  logic [WIDTH-1:0]     period;
  logic [N-1:0]         req;
  logic                 tick;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] last_id;

  // Host side: programs the prescaler, raises requests, watches grants.
  modport master (
    output enable, period, req,
    input  tick, grant, last_id
  );

  // Scheduler side.
  modport slave (
    input  enable, period, req,
    output tick, grant, last_id
  );

endinterface

// File: rtl/tick_rr_scheduler_prescaler.sv
// Programmable prescaler: flags a terminal count every period+1 enabled cycles.
module tick_prescaler #(
  parameter int WIDTH = tick_sched_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  output logic             term
);

  logic [WIDTH-1:0] ps;

  // Terminal compare is >= so a period lowered below the running count
  // terminates on the next enabled cycle instead of wrapping the counter.
  always_comb begin
    term = enable && (ps >= period);
  end

  // Count enabled cycles, restart on terminal count, hold while disabled.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop in the
    // design samples pre-edge values regardless of block ordering.
    if (reset) begin
      ps <= '0;
    end else if (term) begin
      ps <= '0;
    end else if (enable) begin
      ps <= ps + 1'b1;
    end
  end

endmodule

// File: rtl/tick_rr_scheduler.sv
// Periodic tick generator with a round-robin grant to one of N requesters per tick.
module tick_rr_scheduler
  import tick_sched_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  tick_rr_scheduler_if.slave    bus
);

  localparam int ID_W = $clog2(N);

  logic             term;
  logic [ID_W-1:0]  ptr;
  logic [MAX_N-1:0] req_ext;
  rr_pick_t         pick;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  ptr_nxt;
  logic [N-1:0]     grant_nxt;

  tick_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .period (bus.period),
    .term   (term)
  );

  // Search for the next requester starting at the round-robin pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a value unassigned and infers a latch.
    req_ext          = '0;
    req_ext[N-1:0]   = bus.req;
    pick             = rr_pick(req_ext, int'(ptr), N);
    win_id           = ID_W'(pick.idx);
    ptr_nxt          = (int'(pick.idx) == N - 1) ? '0 : ID_W'(pick.idx + 1'b1);
    grant_nxt        = '0;
    if (term && pick.valid) begin
      grant_nxt[win_id] = 1'b1;
    end
  end

  // Register the tick and grant; advance the pointer only on a real grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      bus.tick    <= 1'b0;
      bus.grant   <= '0;
      bus.last_id <= '0;
    end else begin
      bus.tick  <= term;
      bus.grant <= grant_nxt;
      if (term && pick.valid) begin
        ptr         <= ptr_nxt;
        bus.last_id <= win_id;
      end
    end
  end

endmodule
